pcs_rx: RTL
===========

// Module: pcs_rx
// PURPOSE
//  100BASE-X receive PCS stage that sits directly downstream of the descrambler.
//  - Consumes the descrambled serial bit stream, 0-2 bits per clk.
//  - Detects carrier and aligns on the /J/K/ start-of-stream delimiter (SSD).
//  - Decodes 5B code-groups to MII nibbles.
//  - Flags false carrier, invalid codes and premature stream end.
// PARAMETERS
//  none (code-group values are constants in pcs.vh)
// PORTS
//  clk                in   1  system clock, 125 MHz; all logic on its rising edge
//  rst                in   1  synchronous, active-high reset
//  descrambled        in   2  bits from descrambler; [1] is older when 2 valid
//  descrambled_valid  in   2  0 = none, 1 = one bit in [1], 2 = both bits valid
//  locked             in   1  descrambler lock; 0 forces IDLE
//  rx_ce              out  1  one-cycle strobe; rxd/rx_dv/rx_er are meaningful only when 1
//  rxd                out  4  decoded nibble
//  rx_dv              out  1  data valid (qualified by rx_ce)
//  rx_er              out  1  receive error (qualified by rx_ce)
//  crs                out  1  carrier sense, level
//  false_carrier      out  1  one-cycle pulse on a bad SSD
// BEHAVIOUR
//  Reset / outputs
//  - Reset: state=IDLE; every output is 0; window W and counters cleared.
//  - All outputs are registered.
//  Bit window and grouping
//  - W[9:0] holds the last 10 bits, W[0] newest. Each valid bit shifts in, [1] first.
//  - grp_cnt (0-4) counts bits of the current group.
//  - At most one group completes per clk: if valid=2 and grp_cnt=4, the group ends on
//    bit [1] and bit [0] is bit 0 of the next group.
//  IDLE (crs=0)
//  - On the first 0 bit: state=SSD, crs<=1, 7 more bits are awaited.
//  - The two bits ahead of that 0 are idle 1s, so W is then aligned on J.
//  SSD
//  - After 7 bits, compare W against 11000_10001 (J,K).
//  - Match: state=RECEIVE, grp_cnt=0. Emit rx_ce with rxd=0101, rx_dv=1.
//    On the next clk emit a second rx_ce with rxd=0101, rx_dv=1 (pending-preamble flag).
//  - Mismatch: rx_ce with rx_dv=0, rx_er=1, rxd=1110; false_carrier pulse;
//    state=WAIT_IDLE.
//  RECEIVE — on each completed group:
//  - Data code (16 values): rx_ce, rx_dv=1, rx_er=0, rxd=decoded nibble.
//  - T (01101): state=END_T, no strobe.
//  - I (11111), premature end: rx_ce, rx_dv=1, rx_er=1; state=WAIT_IDLE.
//  - Any other code (H, J, K, R, invalid): rx_ce, rx_dv=1, rx_er=1; stay in RECEIVE.
//  END_T — next group:
//  - R (00111): rx_ce, rx_dv=0, rx_er=0; state=IDLE, crs<=0.
//  - Anything else: rx_ce, rx_dv=1, rx_er=1; state=WAIT_IDLE.
//  WAIT_IDLE (crs=1)
//  - Count consecutive 1 bits (4-bit counter, cleared by any 0).
//  - At 10 ones: state=IDLE, crs<=0.
//  Lock loss and simultaneous events
//  - locked=0 in RECEIVE or END_T: one rx_ce with rx_dv=1, rx_er=1; then IDLE, crs=0.
//  - locked=0 in any other state: IDLE silently.
//  - While locked=0, input bits are ignored.
//  - A pending second preamble nibble has priority; no data group can complete within
//    one clk of the SSD match.
//  - rst takes precedence over every other event, including mid-stream.
// STRUCTURE
//  - pcs.vh: CODE_J, CODE_K, CODE_T, CODE_R, CODE_I, CODE_H, PREAMBLE=4'b0101,
//    FALSE_CARRIER=4'b1110, state encodings.
//  - Sub-module pcs_5b4b_decode (combinational): in 5b code; out nibble[3:0], is_data,
//    is_t, is_r, is_i.
//  - Top level: window/shift logic, grp_cnt, FSM, output registers.
// TESTING
//  - Idle stream, then J,K,0x5 x14,0xD, T,R
//    -> 2x rxd=0101 dv=1, 15 data nibbles dv=1 er=0, end strobe dv=0; crs drops.
//  - Idle, then 1100010101 (K replaced by 10101)
//    -> one strobe rxd=1110 dv=0 er=1, false_carrier pulse; IDLE after 10 ones.
//  - Frame with 0x00 replaced by code 00000 mid-stream
//    -> that strobe has dv=1 er=1; next nibbles are clean; end still detected.
//  - Frame ending in T then I -> strobe with dv=1 er=1, state WAIT_IDLE, crs=0
//    after 10 ones.
//  - Valid-pattern sweep: same frame delivered with random 0/1/2 bits per clk,
//    including groups split at grp_cnt=4 -> nibble sequence identical to the
//    1-bit/clk run.
//  - locked dropped mid-frame -> one dv=1 er=1 strobe, crs=0 next clk.
//    rst mid-frame -> all outputs 0 next clk.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// pcs_rx_pkg: shared constants for the 100BASE-X receive PCS.
//   5B code-groups (leftmost bit is received first), the J/K start-of-stream
//   delimiter, fixed nibbles driven on the MII, and FSM state encodings.
package pcs_rx_pkg;
  localparam logic [4:0] CODE_J = 5'b11000;
  localparam logic [4:0] CODE_K = 5'b10001;
  localparam logic [4:0] CODE_T = 5'b01101;
  localparam logic [4:0] CODE_R = 5'b00111;
  localparam logic [4:0] CODE_I = 5'b11111;

  // Window image of /J/K/ with W[9] the oldest bit.
  localparam logic [9:0] SSD_JK = {CODE_J, CODE_K};

  localparam logic [3:0] PREAMBLE      = 4'b0101;
  localparam logic [3:0] FALSE_CARRIER = 4'b1110;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SSD       = 3'd1;
  localparam logic [2:0] ST_RECEIVE   = 3'd2;
  localparam logic [2:0] ST_END_T     = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
endpackage

// File: rtl/pcs_rx_if.sv
// pcs_rx_if: bundles the descrambler-side input and the MII-side output of
// the receive PCS.
//   descrambled[1:0]       bits from the descrambler, [1] older
//   descrambled_valid[1:0] 0 none, 1 bit [1] only, 2 both bits
//   locked                 descrambler lock
//   rx_ce/rxd/rx_dv/rx_er  MII strobe, nibble, data valid, error
//   crs                    carrier sense level
//   false_carrier          one-cycle pulse on a bad SSD
// slave is the PCS side, master the stream source / MII sink side.
interface pcs_rx_if;
  logic [1:0] descrambled;
  logic [1:0] descrambled_valid;
  logic       locked;
  logic       rx_ce;
  logic [3:0] rxd;
  logic       rx_dv;
  logic       rx_er;
  logic       crs;
  logic       false_carrier;

  modport master (
    output descrambled, descrambled_valid, locked,
    input  rx_ce, rxd, rx_dv, rx_er, crs, false_carrier
  );

  modport slave (
    input  descrambled, descrambled_valid, locked,
    output rx_ce, rxd, rx_dv, rx_er, crs, false_carrier
  );
endinterface

// File: rtl/pcs_rx_5b4b_decode.sv
// pcs_rx_5b4b_decode: combinational 5B -> 4B code-group decoder.
//   code    in  5  code-group, leftmost bit received first
//   nibble  out 4  decoded data nibble (0 for non-data codes)
//   is_data out 1  code is one of the 16 data code-groups
//   is_t    out 1  code is /T/
//   is_r    out 1  code is /R/
//   is_i    out 1  code is /I/
module pcs_rx_5b4b_decode
  import pcs_rx_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] nibble,
  output logic       is_data,
  output logic       is_t,
  output logic       is_r,
  output logic       is_i
);

  always_comb begin
    is_data = 1'b1;
    nibble  = 4'h0;
    case (code)
      5'b11110: nibble = 4'h0;
      5'b01001: nibble = 4'h1;
      5'b10100: nibble = 4'h2;
      5'b10101: nibble = 4'h3;
      5'b01010: nibble = 4'h4;
      5'b01011: nibble = 4'h5;
      5'b01110: nibble = 4'h6;
      5'b01111: nibble = 4'h7;
      5'b10010: nibble = 4'h8;
      5'b10011: nibble = 4'h9;
      5'b10110: nibble = 4'hA;
      5'b10111: nibble = 4'hB;
      5'b11010: nibble = 4'hC;
      5'b11011: nibble = 4'hD;
      5'b11100: nibble = 4'hE;
      5'b11101: nibble = 4'hF;
      default:  is_data = 1'b0;
    endcase
  end

  assign is_t = (code == CODE_T);
  assign is_r = (code == CODE_R);
  assign is_i = (code == CODE_I);

endmodule

// File: rtl/pcs_rx.sv
// pcs_rx: 100BASE-X receive PCS downstream of the descrambler.
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  pcs_rx_if.slave: descrambled bit pairs in, MII nibbles/crs/false
//        carrier out. All outputs are registered.
// Up to two bits are consumed per clk, [1] first. Bits shift into a 10-bit
// window; carrier starts on the first 0 in IDLE, the window is then compared
// against /J/K/ seven bits later, and 5-bit groups are decoded after that.
module pcs_rx
  import pcs_rx_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  pcs_rx_if.slave  bus
);

  logic [2:0] state, st_n;
  logic [9:0] w, w_n;
  logic [2:0] grp_cnt, gc_n;
  logic [3:0] ones_cnt, oc_n;
  logic [2:0] ssd_cnt, sc_n;
  logic       pend, pend_n;
  logic       ce_n, dv_n, er_n, fc_n;
  logic [3:0] rxd_n;
  logic       bv, bit_in;

  // At most one group completes per clk: either on bit [1] (grp_cnt=4) or on
  // bit [0] (grp_cnt=3 with two bits), so one decoder on a pre-selected code
  // is enough.
  logic [4:0] code_sel;
  logic [3:0] nib;
  logic       is_data, is_t, is_r, is_i;

  assign code_sel = (grp_cnt == 3'd4) ? {w[3:0], bus.descrambled[1]}
                                      : {w[2:0], bus.descrambled};

  pcs_rx_5b4b_decode u_dec (
    .code    (code_sel),
    .nibble  (nib),
    .is_data (is_data),
    .is_t    (is_t),
    .is_r    (is_r),
    .is_i    (is_i)
  );

  always_comb begin
    st_n   = state;
    w_n    = w;
    gc_n   = grp_cnt;
    oc_n   = ones_cnt;
    sc_n   = ssd_cnt;
    pend_n = 1'b0;
    ce_n   = 1'b0;
    rxd_n  = 4'h0;
    dv_n   = 1'b0;
    er_n   = 1'b0;
    fc_n   = 1'b0;
    bv     = 1'b0;
    bit_in = 1'b0;
    if (!bus.locked) begin
      // Losing lock mid-frame must be visible on the MII as an error.
      if (state == ST_RECEIVE || state == ST_END_T) begin
        ce_n = 1'b1;
        dv_n = 1'b1;
        er_n = 1'b1;
      end
      st_n = ST_IDLE;
      gc_n = 3'd0;
      oc_n = 4'd0;
      sc_n = 3'd0;
    end else begin
      if (pend) begin
        ce_n  = 1'b1;
        dv_n  = 1'b1;
        rxd_n = PREAMBLE;
      end
      for (int i = 0; i < 2; i++) begin
        bv     = (i == 0) ? (bus.descrambled_valid != 2'd0) : bus.descrambled_valid[1];
        bit_in = (i == 0) ? bus.descrambled[1] : bus.descrambled[0];
        if (bv) begin
          w_n = {w_n[8:0], bit_in};
          case (st_n)
            ST_IDLE: begin
              if (!bit_in) begin
                st_n = ST_SSD;
                sc_n = 3'd0;
              end
            end
            ST_SSD: begin
              if (sc_n == 3'd6) begin
                if (w_n == SSD_JK) begin
                  st_n   = ST_RECEIVE;
                  gc_n   = 3'd0;
                  pend_n = 1'b1;
                  ce_n   = 1'b1;
                  dv_n   = 1'b1;
                  rxd_n  = PREAMBLE;
                end else begin
                  st_n  = ST_WAIT_IDLE;
                  oc_n  = 4'd0;
                  ce_n  = 1'b1;
                  er_n  = 1'b1;
                  rxd_n = FALSE_CARRIER;
                  fc_n  = 1'b1;
                end
              end else begin
                sc_n = sc_n + 3'd1;
              end
            end
            ST_RECEIVE, ST_END_T: begin
              if (gc_n == 3'd4) begin
                gc_n = 3'd0;
                ce_n = 1'b1;
                if (st_n == ST_RECEIVE) begin
                  if (is_data) begin
                    dv_n  = 1'b1;
                    rxd_n = nib;
                  end else if (is_t) begin
                    ce_n = 1'b0;
                    st_n = ST_END_T;
                  end else if (is_i) begin
                    dv_n = 1'b1;
                    er_n = 1'b1;
                    st_n = ST_WAIT_IDLE;
                    oc_n = 4'd0;
                  end else begin
                    dv_n = 1'b1;
                    er_n = 1'b1;
                  end
                end else if (is_r) begin
                  st_n = ST_IDLE;
                end else begin
                  dv_n = 1'b1;
                  er_n = 1'b1;
                  st_n = ST_WAIT_IDLE;
                  oc_n = 4'd0;
                end
              end else begin
                gc_n = gc_n + 3'd1;
              end
            end
            ST_WAIT_IDLE: begin
              if (!bit_in)             oc_n = 4'd0;
              else if (oc_n == 4'd9) begin
                st_n = ST_IDLE;
                oc_n = 4'd0;
              end else                 oc_n = oc_n + 4'd1;
            end
            default: st_n = ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      w                 <= 10'd0;
      grp_cnt           <= 3'd0;
      ones_cnt          <= 4'd0;
      ssd_cnt           <= 3'd0;
      pend              <= 1'b0;
      bus.rx_ce         <= 1'b0;
      bus.rxd           <= 4'h0;
      bus.rx_dv         <= 1'b0;
      bus.rx_er         <= 1'b0;
      bus.crs           <= 1'b0;
      bus.false_carrier <= 1'b0;
    end else begin
      state             <= st_n;
      w                 <= w_n;
      grp_cnt           <= gc_n;
      ones_cnt          <= oc_n;
      ssd_cnt           <= sc_n;
      pend              <= pend_n;
      bus.rx_ce         <= ce_n;
      bus.rxd           <= rxd_n;
      bus.rx_dv         <= dv_n;
      bus.rx_er         <= er_n;
      bus.crs           <= (st_n != ST_IDLE);
      bus.false_carrier <= fc_n;
    end
  end

endmodule
